// File: rtl/demux_1x2_13_reg_if.sv
// Stream bundle for the registered 1-to-2 steering stage.
// One producer side plus two consumer ports and their debug transfer counters.
interface demux_1x2_13_reg_if #(
    parameter int WIDTH = 13,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Environment side: drives the producer and both consumers.
    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    // Steering stage side.
    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux_1x2_13_reg.sv
// Registered 1-to-2 steering stage: each output port is a one-entry valid/ready
// holding register with a wrapping transfer counter.
module demux_1x2_13_reg #(
    parameter int WIDTH = 13,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_1x2_13_reg_if.slave     bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_e;

    port_state_e      state_q [2];
    port_state_e      state_d [2];
    logic [WIDTH-1:0] data_q  [2];
    logic [CNT_W-1:0] cnt_q   [2];

    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] load;
    logic [1:0] xfer;
    logic       in_ready;
    logic       in_accept;

    assign valid = {state_q[1] == FULL, state_q[0] == FULL};
    assign ready = {bus.out1_ready, bus.out0_ready};

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        in_ready  = 1'b0;
        in_accept = 1'b0;
        load      = '0;
        xfer      = '0;
        state_d   = state_q;

        // Only the selected port can stall the producer.
        in_ready  = ~valid[bus.in_sel] | ready[bus.in_sel];
        in_accept = bus.in_valid & in_ready;

        for (int k = 0; k < 2; k++) begin
            load[k] = in_accept & (bus.in_sel == k[0]);
            xfer[k] = valid[k] & ready[k];
            case (state_q[k])
                EMPTY:   if (load[k]) state_d[k] = FULL;
                FULL:    if (load[k]) state_d[k] = FULL;
                         else if (xfer[k]) state_d[k] = EMPTY;
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the held words are reset too, because consumers and debug
            // expect out*_data to read 0 after reset, not stale contents.
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                if (load[k]) data_q[k] <= bus.in_data;
                if (xfer[k]) cnt_q[k]  <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_data  = data_q[0];
    assign bus.out0_valid = valid[0];
    assign bus.out1_data  = data_q[1];
    assign bus.out1_valid = valid[1];
    assign bus.cnt0       = cnt_q[0];
    assign bus.cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_1x2_13_reg.sv
// Directed bench for demux_1x2_13_reg: hand-computed expectations checked with
// immediate assertions one step at a time.
module tb_demux_1x2_13_reg;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0]  exp_cnt0;
    logic [7:0]  exp_cnt1;

    demux_1x2_13_reg_if #(.WIDTH(13), .CNT_W(8)) bus ();

    demux_1x2_13_reg #(.WIDTH(13), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;

        reset          = 1'b1;
        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        // Reset held for two edges
        step();
        step();
        check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("rst_out0_data",  32'(bus.out0_data),  32'd0);
        check("rst_out1_data",  32'(bus.out1_data),  32'd0);
        check("rst_cnt0",       32'(bus.cnt0),       32'd0);
        check("rst_cnt1",       32'(bus.cnt1),       32'd0);
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        reset = 1'b0;
        #1;
        check("idle_in_ready",  32'(bus.in_ready),   32'd1);

        // Single route to port 1
        bus.in_data    = 13'h1ABC;
        bus.in_sel     = 1'b1;
        bus.in_valid   = 1'b1;
        bus.out1_ready = 1'b1;
        #1;
        check("route_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("route_out1_valid", 32'(bus.out1_valid), 32'd1);
        check("route_out1_data",  32'(bus.out1_data),  32'h1ABC);
        check("route_cnt1_pre",   32'(bus.cnt1),       32'd0);
        check("route_out0_valid", 32'(bus.out0_valid), 32'd0);
        step();
        exp_cnt1 = exp_cnt1 + 8'd1;
        check("route_out1_drained", 32'(bus.out1_valid), 32'd0);
        check("route_cnt1",         32'(bus.cnt1),       32'(exp_cnt1));
        check("route_out0_still0",  32'(bus.out0_valid), 32'd0);

        // Stall on port 0, skip to port 1
        bus.out0_ready = 1'b0;
        bus.in_data    = 13'h0055;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b1;
        step();
        check("stall_load_valid", 32'(bus.out0_valid), 32'd1);
        check("stall_load_data",  32'(bus.out0_data),  32'h0055);
        bus.in_data = 13'h0066;
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("stall_hold_data",  32'(bus.out0_data),  32'h0055);
        check("stall_hold_valid", 32'(bus.out0_valid), 32'd1);
        check("stall_cnt0",       32'(bus.cnt0),       32'(exp_cnt0));
        bus.in_data = 13'h0077;
        bus.in_sel  = 1'b1;
        #1;
        check("skip_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("skip_out1_data",  32'(bus.out1_data),  32'h0077);
        check("skip_out1_valid", 32'(bus.out1_valid), 32'd1);
        check("skip_out0_data",  32'(bus.out0_data),  32'h0055);
        bus.out0_ready = 1'b1;
        step();
        exp_cnt0 = exp_cnt0 + 8'd1;
        exp_cnt1 = exp_cnt1 + 8'd1;
        check("release_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("release_cnt0",       32'(bus.cnt0),       32'(exp_cnt0));
        check("release_cnt1",       32'(bus.cnt1),       32'(exp_cnt1));

        // Back-to-back throughput on port 0
        bus.in_sel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.in_data  = 13'(13'h0100 + i);
            bus.in_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            check("b2b_out0_valid", 32'(bus.out0_valid), 32'd1);
            check("b2b_out0_data",  32'(bus.out0_data),  32'(13'h0100 + i));
        end
        bus.in_valid = 1'b0;
        step();
        exp_cnt0 = exp_cnt0 + 8'd20;
        check("b2b_cnt0",       32'(bus.cnt0),       32'(exp_cnt0));
        check("b2b_out0_empty", 32'(bus.out0_valid), 32'd0);

        // Counter wrap on port 1: 257 transfers
        bus.in_sel = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.in_data  = 13'(i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        exp_cnt1 = exp_cnt1 + 8'd1;
        check("wrap_cnt1",       32'(bus.cnt1),       32'(exp_cnt1));
        check("wrap_out1_empty", 32'(bus.out1_valid), 32'd0);

        // Reset mid-operation with both ports full
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_data    = 13'h0AAA;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b1;
        step();
        bus.in_data = 13'h0BBB;
        bus.in_sel  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("mid_out0_full", 32'(bus.out0_valid), 32'd1);
        check("mid_out1_full", 32'(bus.out1_valid), 32'd1);
        check("mid_out1_data", 32'(bus.out1_data),  32'h0BBB);
        reset          = 1'b1;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        step();
        check("midrst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("midrst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("midrst_cnt0",       32'(bus.cnt0),       32'd0);
        check("midrst_cnt1",       32'(bus.cnt1),       32'd0);
        check("midrst_out0_data",  32'(bus.out0_data),  32'd0);
        reset = 1'b0;
        step();
        check("post_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("post_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("post_cnt1",       32'(bus.cnt1),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
